tpu_sequencer: RTL and testbench

Sequencing controller for the 4x4 weight-stationary systolic array (`TPU`: `control`, `data_arr`, `wt_arr`, `pe30_out`..`pe33_out`).
- On each job it loads a 4x4 weight matrix column by column.
- It then streams input vectors into the array with the diagonal skew the array requires, injecting zero bubbles where no data is available.
- It waits for the pipeline to drain, captures the bottom-row accumulators, and returns them over a valid/ready result port.
- It replaces hand-driven testbench stimulus with a synthesizable front end.

---
 rtl/tpu_sequencer_if.sv | 46 ++++
 rtl/tpu_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_tpu_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_sequencer_if.sv
// ---------------------------------------------------------------------------
// tpu_sequencer_if
// Bundles the job, input-stream, result and systolic-array drive signals of
// the TPU sequencer.
//   slave  : the sequencer itself
//   master : the host / array side (job source, vector source, result sink,
//            and the bottom-row accumulator feed from the array)
// Signals:
//   start, cfg_nvec, wt_mat           job request and its configuration
//   in_valid, in_ready, in_vec        input vector stream
//   res_valid, res_ready, res_data    captured accumulator result
//   busy                              sequencer not idle
//   tpu_control, tpu_wt_arr,
//   tpu_data_arr                      drives of the systolic array
//   tpu_acc_row                       {pe33_out, pe32_out, pe31_out, pe30_out}
// ---------------------------------------------------------------------------
interface tpu_sequencer_if #(
    parameter int BIT_WIDTH = 16,
    parameter int ACC_WIDTH = 40,
    parameter int DEPTH     = 4
);
    logic                               start;
    logic [7:0]                         cfg_nvec;
    logic [DEPTH*DEPTH*BIT_WIDTH-1:0]   wt_mat;
    logic                               in_valid;
    logic                               in_ready;
    logic [DEPTH*BIT_WIDTH-1:0]         in_vec;
    logic                               res_valid;
    logic                               res_ready;
    logic [DEPTH*ACC_WIDTH-1:0]         res_data;
    logic                               busy;
    logic                               tpu_control;
    logic [DEPTH*BIT_WIDTH-1:0]         tpu_wt_arr;
    logic [DEPTH*BIT_WIDTH-1:0]         tpu_data_arr;
    logic [DEPTH*ACC_WIDTH-1:0]         tpu_acc_row;

    modport slave (
        input  start, cfg_nvec, wt_mat, in_valid, in_vec, res_ready, tpu_acc_row,
        output in_ready, res_valid, res_data, busy, tpu_control, tpu_wt_arr, tpu_data_arr
    );

    modport master (
        output start, cfg_nvec, wt_mat, in_valid, in_vec, res_ready, tpu_acc_row,
        input  in_ready, res_valid, res_data, busy, tpu_control, tpu_wt_arr, tpu_data_arr
    );
endinterface

// File: rtl/tpu_sequencer.sv
// ---------------------------------------------------------------------------
// tpu_sequencer
// Front end for the DEPTH x DEPTH weight-stationary systolic array. Per job it
// loads the weight matrix column by column, streams input vectors through a
// diagonal skew buffer (zero bubbles where no vector is accepted), drains the
// array, captures the bottom-row accumulators and offers them on a
// valid/ready result port.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   sif    : tpu_sequencer_if.slave (job, stream, result and array drives)
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for start; latches cfg_nvec / wt_mat on start
//   S_LOAD_W | tpu_control=1, one weight column per cycle (DEPTH cycles)
//   S_GAP    | one quiet cycle between weight load and data
//   S_STREAM | accepting nvec vectors; bubbles on cycles without accept
//   S_FLUSH  | zero injection for skew flush plus drain, capture at end
//   S_RESULT | res_valid held until res_ready
// ---------------------------------------------------------------------------
module tpu_sequencer #(
    parameter int BIT_WIDTH = 16,
    parameter int ACC_WIDTH = 40,
    parameter int DEPTH     = 4,
    parameter int DRAIN_CYC = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    tpu_sequencer_if.slave  sif
);

    localparam int VW = DEPTH * BIT_WIDTH;
    localparam int MW = DEPTH * VW;
    localparam int RW = DEPTH * ACC_WIDTH;

    // Terminal-count values of the shared down-counter.
    localparam logic [7:0] K_LAST     = 8'(DEPTH - 1);
    localparam logic [7:0] FLUSH_LAST = 8'(DEPTH - 1 + DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_GAP,
        S_STREAM,
        S_FLUSH,
        S_RESULT
    } state_t;

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [7:0]       r_acc;
    logic [7:0]       r_nvec;
    logic [MW-1:0]    r_wt_mat;
    logic             r_tpu_control;
    logic [VW-1:0]    r_tpu_wt_arr;
    logic             r_res_valid;
    logic [RW-1:0]    r_res_data;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [7:0]       w_cnt_nxt;
    logic [7:0]       w_acc_nxt;
    logic             w_control_nxt;
    logic [VW-1:0]    w_wt_arr_nxt;
    logic             w_res_valid_nxt;
    logic             w_latch;
    logic             w_capture;
    logic             w_in_ready;
    logic             w_accept;
    logic [7:0]       w_k_nxt;
    logic [VW-1:0]    w_col_sel;
    logic [VW-1:0]    w_entry;
    logic [VW-1:0]    w_data_arr;

    assign w_in_ready = (r_state == S_STREAM) && (r_acc < r_nvec);
    assign w_accept   = w_in_ready && sif.in_valid;
    assign w_entry    = w_accept ? sif.in_vec : '0;

    // LOAD_W counts down from K_LAST, so the column for the next cycle is
    // K_LAST - r_cnt + 1.
    assign w_k_nxt = K_LAST - r_cnt + 8'd1;

    always_comb begin
        w_col_sel = '0;
        for (int c = 0; c < DEPTH; c++) begin
            if (w_k_nxt == 8'(c)) begin
                w_col_sel = r_wt_mat[c*VW +: VW];
            end
        end
    end

    // Registered array drives are computed one cycle ahead so that they line
    // up with the state they belong to.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_acc_nxt       = r_acc;
        w_control_nxt   = 1'b0;
        w_wt_arr_nxt    = '0;
        w_res_valid_nxt = r_res_valid;
        w_latch         = 1'b0;
        w_capture       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (sif.start) begin
                    w_latch       = 1'b1;
                    w_state_nxt   = S_LOAD_W;
                    w_cnt_nxt     = K_LAST;
                    w_acc_nxt     = '0;
                    w_control_nxt = 1'b1;
                    // Column 0 comes straight from the port; the latch
                    // lands on the same edge.
                    w_wt_arr_nxt  = sif.wt_mat[VW-1:0];
                end
            end

            S_LOAD_W: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = S_GAP;
                end else begin
                    w_cnt_nxt     = r_cnt - 8'd1;
                    w_control_nxt = 1'b1;
                    w_wt_arr_nxt  = w_col_sel;
                end
            end

            S_GAP: begin
                if (r_nvec == 8'd0) begin
                    w_state_nxt = S_FLUSH;
                    w_cnt_nxt   = FLUSH_LAST;
                end else begin
                    w_state_nxt = S_STREAM;
                end
            end

            S_STREAM: begin
                w_acc_nxt = r_acc + {7'd0, w_accept};
                if (w_acc_nxt == r_nvec) begin
                    w_state_nxt = S_FLUSH;
                    w_cnt_nxt   = FLUSH_LAST;
                end
            end

            S_FLUSH: begin
                if (r_cnt == 8'd0) begin
                    w_capture       = 1'b1;
                    w_res_valid_nxt = 1'b1;
                    w_state_nxt     = S_RESULT;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end

            S_RESULT: begin
                if (sif.res_ready) begin
                    w_res_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_acc         <= '0;
            r_nvec        <= '0;
            r_wt_mat      <= '0;
            r_tpu_control <= 1'b0;
            r_tpu_wt_arr  <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_acc         <= w_acc_nxt;
            r_tpu_control <= w_control_nxt;
            r_tpu_wt_arr  <= w_wt_arr_nxt;
            r_res_valid   <= w_res_valid_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
            if (w_latch) begin
                r_nvec   <= sif.cfg_nvec;
                r_wt_mat <= sif.wt_mat;
            end
            if (w_capture) begin
                r_res_data <= sif.tpu_acc_row;
            end
        end
    end

    // Skew buffer: lane i is a chain of i+1 registers, the last one being
    // the lane's output register. Every cycle shifts, so bubbles and flush
    // zeros fall out of the same path as accepted data.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lane
        logic [BIT_WIDTH-1:0] r_stg [0:gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s <= gi; s++) begin
                    r_stg[s] <= '0;
                end
            end else begin
                r_stg[0] <= w_entry[gi*BIT_WIDTH +: BIT_WIDTH];
                for (int s = 1; s <= gi; s++) begin
                    r_stg[s] <= r_stg[s-1];
                end
            end
        end

        assign w_data_arr[gi*BIT_WIDTH +: BIT_WIDTH] = r_stg[gi];
    end

    assign sif.in_ready     = w_in_ready;
    assign sif.res_valid    = r_res_valid;
    assign sif.res_data     = r_res_data;
    assign sif.busy         = r_busy;
    assign sif.tpu_control  = r_tpu_control;
    assign sif.tpu_wt_arr   = r_tpu_wt_arr;
    assign sif.tpu_data_arr = w_data_arr;

endmodule

// File: tb/tb_tpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tpu_sequencer
// Self-checking bench for tpu_sequencer: a table of directed jobs, literal
// skew rows, a mid-stream reset, and randomized jobs checked against a
// behavioural model (entry history per edge, latency formula, captured row).
// ---------------------------------------------------------------------------
module tb_tpu_sequencer;

    localparam int BW = 16;
    localparam int AW = 40;
    localparam int D  = 4;
    localparam int DC = 8;
    localparam int VW = D * BW;
    localparam int MW = D * VW;
    localparam int RW = D * AW;

    typedef struct {
        int nvec;
        bit fixed;
        int stall_at;
        int stall_len;
        int rdy_wait;
        int rst_after;
        int exp_lat;
    } job_t;

    logic clk;
    logic rst_n;

    tpu_sequencer_if #(.BIT_WIDTH(BW), .ACC_WIDTH(AW), .DEPTH(D)) sif ();

    tpu_sequencer #(.BIT_WIDTH(BW), .ACC_WIDTH(AW), .DEPTH(D), .DRAIN_CYC(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_chk;
    int            n_fail;
    logic [VW-1:0] hist [D];
    logic [VW-1:0] pend;
    logic [RW-1:0] acc_at_edge;
    logic [MW-1:0] spec_wt;
    logic [VW-1:0] rows [7];
    job_t          jobs [7];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // One clock: record what enters the skew buffer at this edge, then
    // compare every lane against the entry made i edges ago.
    task automatic tick();
        logic [VW-1:0] e;
        logic [RW-1:0] r;
        pend        = (sif.in_valid && sif.in_ready && rst_n) ? sif.in_vec : '0;
        acc_at_edge = sif.tpu_acc_row;
        @(posedge clk);
        #1;
        for (int i = D - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = pend;
        for (int i = 0; i < D; i++) e[i*BW +: BW] = hist[i][i*BW +: BW];
        chk("skew", sif.tpu_data_arr, e);
        for (int w = 0; w < RW / 32; w++) r[w*32 +: 32] = $urandom;
        sif.tpu_acc_row = r;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  sif.busy,         1'b0);
        chk({tag, "_rv"},    sif.res_valid,    1'b0);
        chk({tag, "_rd"},    sif.res_data,     '0);
        chk({tag, "_ctrl"},  sif.tpu_control,  1'b0);
        chk({tag, "_wt"},    sif.tpu_wt_arr,   '0);
        chk({tag, "_data"},  sif.tpu_data_arr, '0);
        chk({tag, "_rdy"},   sif.in_ready,     1'b0);
    endtask

    task automatic run_job(input int nvec, input bit fixed, input int stall_at,
                           input int stall_len, input int pct, input int rdy_wait,
                           input int rst_after, output int lat);
        logic [MW-1:0] wt;
        logic [VW-1:0] v;
        logic [VW-1:0] vecs [$];
        logic [RW-1:0] cap;
        int            acc;
        int            stalls;
        int            edges;
        int            since;
        int            sl;
        bit            vld;
        bit            taken;

        lat = -1;
        if (fixed) wt = spec_wt;
        else for (int w = 0; w < MW / 32; w++) wt[w*32 +: 32] = $urandom;
        for (int j = 0; j < nvec; j++) begin
            for (int i = 0; i < D; i++) begin
                if (fixed) v[i*BW +: BW] = BW'(D * i + j);
                else       v[i*BW +: BW] = BW'($urandom);
            end
            vecs.push_back(v);
        end

        sif.start     = 1'b1;
        sif.cfg_nvec  = 8'(nvec);
        sif.wt_mat    = wt;
        sif.in_valid  = 1'b1;
        sif.in_vec    = {$urandom, $urandom};
        sif.res_ready = 1'b0;
        tick();
        sif.start    = 1'b0;
        sif.cfg_nvec = ~8'(nvec);
        sif.wt_mat   = ~wt;

        for (int k = 0; k < D; k++) begin
            chk("ctrl_load", sif.tpu_control, 1'b1);
            chk("wt_col",    sif.tpu_wt_arr,  wt[k*VW +: VW]);
            chk("busy_load", sif.busy,        1'b1);
            chk("rdy_load",  sif.in_ready,    1'b0);
            sif.start = 1'($urandom_range(0, 1));
            tick();
        end
        sif.start = 1'b0;
        chk("ctrl_gap", sif.tpu_control, 1'b0);
        chk("wt_gap",   sif.tpu_wt_arr,  '0);
        chk("rdy_gap",  sif.in_ready,    1'b0);
        tick();

        edges  = D + 1;
        acc    = 0;
        stalls = 0;
        since  = 0;
        sl     = stall_len;
        while (edges < 600) begin
            chk("in_ready", sif.in_ready,    acc < nvec);
            chk("ctrl_run", sif.tpu_control, 1'b0);
            chk("wt_run",   sif.tpu_wt_arr,  '0);
            if (rst_after >= 0 && acc == rst_after) begin
                sif.in_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                check_all_zero("rst_mid");
                for (int i = 0; i < D; i++) hist[i] = '0;
                tick();
                chk("rst_hold_busy", sif.busy, 1'b0);
                rst_n = 1'b1;
                tick();
                chk("rst_idle_busy", sif.busy,     1'b0);
                chk("rst_idle_rdy",  sif.in_ready, 1'b0);
                return;
            end
            vld = 1'b1;
            if (acc == stall_at && sl > 0) begin
                vld = 1'b0;
                sl--;
            end else if ($urandom_range(0, 99) < pct) begin
                vld = 1'b0;
            end
            sif.in_valid = vld;
            sif.in_vec   = (vld && acc < nvec) ? vecs[acc] : {$urandom, $urandom};
            if (sif.in_ready && !vld) stalls++;
            taken = sif.in_ready && vld;
            tick();
            edges++;
            if (since > 0) since++;
            if (taken && acc == 0) since = 1;
            if (taken) acc++;
            if (fixed && stall_len == 0 && pct == 0 && since >= 1 && since <= 7)
                chk("skew_row", sif.tpu_data_arr, rows[since-1]);
            if (sif.res_valid) break;
        end

        chk("res_valid_seen", sif.res_valid, 1'b1);
        if (!sif.res_valid) return;
        lat = edges;
        chk("latency",  edges, D + 1 + nvec + (D - 1) + DC + stalls);
        chk("accepted", acc, nvec);
        cap = acc_at_edge;
        chk("res_data", sif.res_data, cap);

        sif.in_valid = 1'b1;
        for (int r = 0; r < rdy_wait; r++) begin
            sif.start = 1'($urandom_range(0, 1));
            tick();
            chk("res_hold_valid", sif.res_valid, 1'b1);
            chk("res_hold_data",  sif.res_data,  cap);
            chk("res_hold_busy",  sif.busy,      1'b1);
            chk("res_hold_rdy",   sif.in_ready,  1'b0);
        end
        sif.start     = 1'b0;
        sif.in_valid  = 1'b0;
        sif.res_ready = 1'b1;
        tick();
        chk("res_drop",  sif.res_valid, 1'b0);
        chk("idle_busy", sif.busy,      1'b0);
        sif.res_ready = 1'b0;
        tick();
        chk("no_queue",  sif.busy,      1'b0);
    endtask

    initial begin
        int lat;
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < D; i++) hist[i] = '0;
        spec_wt = {64'h0001_0000_0000_0000, 64'h0000_0001_0000_0000,
                   64'h0000_0000_0001_0000, 64'h0000_0000_0000_8001};
        rows[0] = 64'h0000_0000_0000_0000;
        rows[1] = 64'h0000_0000_0004_0001;
        rows[2] = 64'h0000_0008_0005_0002;
        rows[3] = 64'h000c_0009_0006_0003;
        rows[4] = 64'h000d_000a_0007_0000;
        rows[5] = 64'h000e_000b_0000_0000;
        rows[6] = 64'h000f_0000_0000_0000;
        //          nvec fixed stall_at stall_len rdy_wait rst_after exp_lat
        jobs[0] = '{4,   1'b1, -1,      0,        0,       -1,       20};
        jobs[1] = '{4,   1'b1,  2,      2,        5,       -1,       22};
        jobs[2] = '{0,   1'b0, -1,      0,        0,       -1,       16};
        jobs[3] = '{4,   1'b1, -1,      0,        0,        2,       -1};
        jobs[4] = '{1,   1'b0, -1,      0,        1,       -1,       17};
        jobs[5] = '{4,   1'b1, -1,      0,        2,       -1,       20};
        jobs[6] = '{255, 1'b0, -1,      0,        0,       -1,       271};

        rst_n           = 1'b0;
        sif.start       = 1'b0;
        sif.cfg_nvec    = '0;
        sif.wt_mat      = '0;
        sif.in_valid    = 1'b0;
        sif.in_vec      = '0;
        sif.res_ready   = 1'b0;
        sif.tpu_acc_row = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        foreach (jobs[n]) begin
            run_job(jobs[n].nvec, jobs[n].fixed, jobs[n].stall_at, jobs[n].stall_len,
                    0, jobs[n].rdy_wait, jobs[n].rst_after, lat);
            if (jobs[n].rst_after < 0) chk("tbl_latency", lat, jobs[n].exp_lat);
        end

        for (int n = 0; n < 10; n++) begin
            run_job($urandom_range(0, 10), 1'b0, -1, 0, 30, $urandom_range(0, 3), -1, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
